fb_rect_fill: RTL and testbench

Drawing engine upstream of the VGA scan-out stage. It accepts rectangle-fill commands and writes the fill colour into the 640x480, 12-bit RGB frame buffer's write port, one pixel per clock, in raster order. The frame buffer's read port is consumed by the scan-out stage using the same linear addressing, addr = y*640 + x.

---
 rtl/fb_pkg.sv | 36 +++
 rtl/fb_addr_gen.sv | 56 +++++
 rtl/fb_rect_fill.sv | 118 +++++++++++
 tb/tb_fb_rect_fill.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants for the drawing engine and the scan-out stage.
// Holds the raster geometry, bus widths, the row stride, the FSM state codes
// and small helpers used when a fill command is accepted.
package fb_pkg;

  // Raster geometry and bus widths shared with the scan-out stage.
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int AW    = 19;
  localparam int CW    = 12;

  // Width of the command coordinate and size fields.
  localparam int XW = 10;

  // Distance in the linear address space between vertically adjacent pixels.
  localparam logic [AW-1:0] ROW_STRIDE = AW'(H_RES);

  // Engine states, kept as plain constants so older tools decode them alike.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Linear address of pixel (x, y): y*640 + x, using y*512 + y*128 so that
  // only adders are built. The result wraps modulo 2^AW.
  function automatic logic [AW-1:0] pixel_addr(input logic [XW-1:0] x,
                                               input logic [XW-1:0] y);
    return (AW'(y) << 9) + (AW'(y) << 7) + AW'(x);
  endfunction

  // Smaller of two size fields; used when a rectangle is clipped to the screen.
  function automatic logic [XW-1:0] min_dim(input logic [XW-1:0] a,
                                            input logic [XW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster address walker for one rectangle fill.
// Keeps the column/row counters and the row-start accumulator, and presents
// the address of the pixel currently being written plus a last-pixel flag.
// The address is held in its own register and advanced by +1 along a row or
// reloaded from row_base + stride at a row end, so the output has no adder
// in front of it.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,   // load the first pixel of a new rectangle
  input  logic          step,    // advance to the next pixel in raster order
  input  logic [AW-1:0] base,    // address of the top-left pixel
  input  logic [XW-1:0] w_last,  // rectangle width minus one
  input  logic [XW-1:0] h_last,  // rectangle height minus one
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [XW-1:0] cx;
  logic [XW-1:0] cy;
  logic [AW-1:0] row_base;
  logic          row_end;

  assign row_end = (cx == w_last);
  assign last    = row_end && (cy == h_last);

  // Walk the rectangle: reload on start, then step along rows and down.
  // NOTE: every register here is assigned with <= so all of them update
  // together from the values they held before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (start) begin
      cx       <= '0;
      cy       <= '0;
      row_base <= base;
      addr     <= base;
    end else if (step) begin
      if (row_end) begin
        cx       <= '0;
        cy       <= cy + XW'(1);
        row_base <= row_base + ROW_STRIDE;
        addr     <= row_base + ROW_STRIDE;
      end else begin
        cx   <= cx + XW'(1);
        addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill drawing engine feeding the frame-buffer write port.
// Accepts one command at a time over a valid/ready handshake and writes the
// fill colour one pixel per clock in raster order, then pulses done.
// Optional build macro FB_RECT_FILL_CLIP_EN clips each rectangle to the
// visible screen at accept time; without it addresses simply wrap.
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [XW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [XW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_color,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [CW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  logic [1:0]    state;
  logic [XW-1:0] w_q;
  logic [XW-1:0] h_q;
  logic [CW-1:0] color_q;

  logic [XW-1:0] eff_w;
  logic [XW-1:0] eff_h;
  logic          zero_size;
  logic          accept;
  logic          start;
  logic          step;
  logic          last;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign wr_data   = color_q;

  assign accept = cmd_valid && cmd_ready;
  assign start  = accept && !zero_size;
  assign step   = (state == FILL) && !last;

  // Effective rectangle size seen by the engine, clipped when enabled.
  // NOTE: both outputs get a value before any branch so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    eff_w = cmd_w;
    eff_h = cmd_h;
`ifdef FB_RECT_FILL_CLIP_EN
    if ((cmd_x >= XW'(H_RES)) || (cmd_y >= XW'(V_RES))) begin
      eff_w = '0;
      eff_h = '0;
    end else begin
      eff_w = min_dim(cmd_w, XW'(H_RES) - cmd_x);
      eff_h = min_dim(cmd_h, XW'(V_RES) - cmd_y);
    end
`endif
    zero_size = (eff_w == '0) || (eff_h == '0);
  end

  // Command sequencing: accept, stream the fill, report completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            w_q     <= eff_w;
            h_q     <= eff_h;
            color_q <= cmd_color;
            if (zero_size) begin
              state <= DONE;
            end else begin
              // The first pixel is presented on the cycle right after accept.
              state <= FILL;
              wr_en <= 1'b1;
            end
          end
        end
        FILL: begin
          if (last) begin
            state <= DONE;
            wr_en <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

  fb_addr_gen u_addr_gen (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .step   (step),
    .base   (pixel_addr(cmd_x, cmd_y)),
    .w_last (w_q - XW'(1)),
    .h_last (h_q - XW'(1)),
    .addr   (wr_addr),
    .last   (last)
  );

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill. Expected writes are produced by a
// rectangle model (row/column loops over the clipped size) and compared with
// every wr_en cycle the DUT produces, including its cycle stamp.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [9:0]  cmd_h;
  logic [11:0] cmd_color;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    int          c;
    logic [18:0] a;
    logic [11:0] d;
  } wr_t;

  typedef struct {
    int          x;
    int          y;
    int          w;
    int          h;
    logic [11:0] col;
  } cmd_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  done_q[$];

  fb_rect_fill dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write and done pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (wr_en === 1'b1) got_q.push_back(wr_t'{cyc, wr_addr, wr_data});
    if (done === 1'b1) done_q.push_back(cyc);
  end

  // Reference: a rectangle accepted in cycle acc is written pixel by pixel
  // in raster order in cycles acc+1 .. acc+n, n = clipped w*h.
  task automatic model_cmd(input cmd_t c, input int acc, output int n);
    int ew = c.w;
    int eh = c.h;
`ifdef FB_RECT_FILL_CLIP_EN
    if (c.x >= 640 || c.y >= 480) begin
      ew = 0;
      eh = 0;
    end else begin
      if (ew > 640 - c.x) ew = 640 - c.x;
      if (eh > 480 - c.y) eh = 480 - c.y;
    end
`endif
    n = ew * eh;
    for (int r = 0; r < eh; r++)
      for (int k = 0; k < ew; k++)
        exp_q.push_back(wr_t'{acc + 1 + r * ew + k, 19'((c.y + r) * 640 + c.x + k), c.col});
  endtask

  task automatic drive_fields(input cmd_t c);
    cmd_x     = 10'(c.x);
    cmd_y     = 10'(c.y);
    cmd_w     = 10'(c.w);
    cmd_h     = 10'(c.h);
    cmd_color = c.col;
  endtask

  // Hold cmd_valid until the handshake is seen; acc is the accepting cycle.
  task automatic wait_accept(output int acc, output bit ok);
    ok  = 1'b0;
    acc = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    drive_fields('{0, 0, 0, 0, 12'h000});
    #12;
    total++; if (wr_en !== 1'b0)    begin bad++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
    total++; if (wr_addr !== 19'd0) begin bad++; $display("FAIL reset wr_addr: got %0d want 0", wr_addr); end
    total++; if (wr_data !== 12'd0) begin bad++; $display("FAIL reset wr_data: got %h want 000", wr_data); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset done: got %b want 0", done); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_fill;
    cmd_t tbl[$];
    tbl.push_back('{0, 0, 4, 2, 12'hF00});
    tbl.push_back('{639, 479, 1, 1, 12'h0F0});
    tbl.push_back('{10, 20, 0, 5, 12'h00F});
    tbl.push_back('{30, 40, 6, 0, 12'h123});
`ifdef FB_RECT_FILL_CLIP_EN
    tbl.push_back('{636, 478, 10, 10, 12'hABC});
    tbl.push_back('{700, 5, 4, 4, 12'h456});
    tbl.push_back('{5, 490, 3, 3, 12'h789});
`endif
    for (int i = 0; i < 12; i++) begin
      cmd_t c;
      c.col = 12'($urandom);
`ifdef FB_RECT_FILL_CLIP_EN
      c.w = int'($urandom_range(0, 12));
      c.h = int'($urandom_range(0, 12));
      c.x = int'($urandom_range(560, 700));
      c.y = int'($urandom_range(440, 500));
`else
      c.w = int'($urandom_range(0, 8));
      c.h = int'($urandom_range(0, 6));
      c.x = int'($urandom_range(0, 640 - c.w));
      c.y = int'($urandom_range(0, 480 - c.h));
`endif
      tbl.push_back(c);
    end

    foreach (tbl[t]) begin
      int acc;
      int n;
      int got_done;
      bit ok;
      got_q.delete();
      exp_q.delete();
      done_q.delete();
      @(posedge clk); #1;
      drive_fields(tbl[t]);
      cmd_valid = 1'b1;
      wait_accept(acc, ok);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL fill[%0d] accept: got no handshake want handshake", t);
        continue;
      end
      model_cmd(tbl[t], acc, n);
      repeat (n + 4) @(negedge clk);
      #1;
      total++;
      if (got_q.size() !== exp_q.size()) begin
        bad++;
        $display("FAIL fill[%0d] write count: got %0d want %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL fill[%0d] write %0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                   t, i, got_q[i].c - acc, got_q[i].a, got_q[i].d, exp_q[i].c - acc, exp_q[i].a, exp_q[i].d);
        end
      end
      got_done = (done_q.size() == 1) ? done_q[0] - acc : -1;
      total++;
      if (got_done !== n + 1) begin
        bad++;
        $display("FAIL fill[%0d] done latency: got %0d (pulses=%0d) want %0d", t, got_done, done_q.size(), n + 1);
      end
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL fill[%0d] idle after done: got ready=%b busy=%b want ready=1 busy=0", t, cmd_ready, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    cmd_t a = '{100, 50, 3, 2, 12'h5A5};
    cmd_t b = '{7, 9, 2, 2, 12'h3C3};
    int acc_a, acc_b, n_a, n_b;
    bit ok_a, ok_b;
    got_q.delete();
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    drive_fields(a);
    cmd_valid = 1'b1;
    wait_accept(acc_a, ok_a);
    @(posedge clk); #1;
    drive_fields(b);
    wait_accept(acc_b, ok_b);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_cmd(a, acc_a, n_a);
    model_cmd(b, acc_b, n_b);
    repeat (n_b + 4) @(negedge clk);
    #1;
    total++;
    if (!(ok_a && ok_b)) begin
      bad++;
      $display("FAIL b2b handshake: got a=%0d b=%0d want both 1", ok_a, ok_b);
    end
    total++;
    if (acc_b - acc_a !== n_a + 2) begin
      bad++;
      $display("FAIL b2b second accept: got %0d cycles want %0d", acc_b - acc_a, n_a + 2);
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL b2b write count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b write %0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                 i, got_q[i].c, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
      end
    end
    total++;
    if (done_q.size() !== 2) begin
      bad++;
      $display("FAIL b2b done pulses: got %0d want 2", done_q.size());
    end else begin
      total++;
      if (done_q[0] !== acc_a + n_a + 1 || done_q[1] !== acc_b + n_b + 1) begin
        bad++;
        $display("FAIL b2b done cycles: got %0d,%0d want %0d,%0d",
                 done_q[0], done_q[1], acc_a + n_a + 1, acc_b + n_b + 1);
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    cmd_t c = '{20, 30, 10, 10, 12'hE71};
    int acc;
    bit ok;
    bit reached = 1'b0;
    got_q.delete();
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    drive_fields(c);
    cmd_valid = 1'b1;
    wait_accept(acc, ok);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cyc == acc + 3) begin
        reached = 1'b1;
        break;
      end
    end
    #1;
    total++;
    if (!(ok && reached) || got_q.size() !== 3) begin
      bad++;
      $display("FAIL midreset pre-writes: got %0d writes (ok=%0d) want 3", got_q.size(), ok);
    end
    rstn = 1'b0;
    #1;
    total++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midreset outputs: got wr_en=%b busy=%b done=%b want 0 0 0", wr_en, busy, done);
    end
    got_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset cmd_ready: got %b want 1", cmd_ready);
    end
    repeat (120) @(negedge clk);
    #1;
    total++;
    if (got_q.size() !== 0 || done_q.size() !== 0) begin
      bad++;
      $display("FAIL midreset stale activity: got writes=%0d done=%0d want 0 0", got_q.size(), done_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
